// File: rtl/wb_tgt_pkg.sv
// Shared types and helpers for the Wishbone target memory model.
package wb_tgt_pkg;

  // Response sequencer states: nothing queued, head waiting out its delay,
  // head being terminated this cycle.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Width of the response delay counter; covers RSP_DELAY 0..15.
  localparam int DLY_W = 4;

  // Lane width for the default 16-bit bus with two selects.
  localparam int LANE_W_DEF = 8;

  // Bits covered by one select line.
  function automatic int lane_width(input int dat_w, input int sel_w);
    return dat_w / sel_w;
  endfunction

endpackage

// File: rtl/wb_tgt_queue.sv
// Synchronous FIFO holding pending responses in acceptance order.
module wb_tgt_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Guard against overflow/underflow even if a caller misbehaves.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/wb_tgt_mem.sv
// Pipelined Wishbone target with word-addressed memory and delayed,
// in-order ack/err terminations.
module wb_tgt_mem
  import wb_tgt_pkg::*;
#(
  parameter int ADR_WIDTH   = 16,
  parameter int DAT_WIDTH   = 16,
  parameter int SEL_WIDTH   = 2,
  parameter int TGA_WIDTH   = 1,
  parameter int TGC_WIDTH   = 1,
  parameter int TGRD_WIDTH  = 1,
  parameter int TGWD_WIDTH  = 1,
  parameter int MEM_DEPTH   = 256,
  parameter int QUEUE_DEPTH = 4,
  parameter int RSP_DELAY   = 0
) (
  input  logic                           clk_i,
  input  logic                           sync_rst_i,
  input  logic                           tb_stall_i,
  input  logic                           tgt_cyc_i,
  input  logic                           tgt_stb_i,
  input  logic                           tgt_we_i,
  input  logic                           tgt_lock_i,
  input  logic [SEL_WIDTH-1:0]           tgt_sel_i,
  input  logic [ADR_WIDTH-1:0]           tgt_adr_i,
  input  logic [DAT_WIDTH-1:0]           tgt_dat_i,
  input  logic [TGA_WIDTH-1:0]           tgt_tga_i,
  input  logic [TGC_WIDTH-1:0]           tgt_tgc_i,
  input  logic [TGWD_WIDTH-1:0]          tgt_tgd_i,
  output logic                           tgt_ack_o,
  output logic                           tgt_err_o,
  output logic                           tgt_rty_o,
  output logic                           tgt_stall_o,
  output logic [DAT_WIDTH-1:0]           tgt_dat_o,
  output logic [TGRD_WIDTH-1:0]          tgt_tgd_o,
  output logic [$clog2(QUEUE_DEPTH):0]   tb_pending_o
);

  localparam int LANE_W = lane_width(DAT_WIDTH, SEL_WIDTH);
  localparam int MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int AL_W   = ADR_WIDTH + 1;
  // Extra bit keeps the range compare exact even when MEM_DEPTH = 2**ADR_WIDTH.
  localparam logic [AL_W-1:0]  ADR_LIM = AL_W'(MEM_DEPTH);
  localparam logic [DLY_W-1:0] DLY     = DLY_W'(RSP_DELAY);

  // One pending termination; read data is captured at accept time.
  typedef struct packed {
    logic                  err;
    logic                  we;
    logic [DAT_WIDTH-1:0]  rdata;
    logic [TGRD_WIDTH-1:0] rtag;
  } entry_t;

  localparam int ENT_W = $bits(entry_t);

  logic [DAT_WIDTH-1:0]  r_mem [MEM_DEPTH];
  logic [TGRD_WIDTH-1:0] r_tag [MEM_DEPTH];
  state_t                r_state;
  logic [DLY_W-1:0]      r_cnt;

  state_t                w_state_nxt;
  logic [DLY_W-1:0]      w_cnt_nxt;
  logic                  w_req;
  logic                  w_adr_ok;
  logic                  w_wr;
  logic [MIDX_W-1:0]     w_idx;
  entry_t                w_push_ent;
  entry_t                w_head;
  logic [ENT_W-1:0]      w_head_bits;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_resp;
  logic                  w_more;
  logic                  w_unused;

  // Stall derives only from registered occupancy, so a request seen
  // without stall at an edge is always taken.
  assign tgt_stall_o = w_full | tb_stall_i;
  assign w_req       = tgt_cyc_i & tgt_stb_i & ~tgt_stall_o & ~sync_rst_i;
  assign w_adr_ok    = ({1'b0, tgt_adr_i} < ADR_LIM);
  assign w_idx       = tgt_adr_i[MIDX_W-1:0];
  assign w_wr        = w_req & tgt_we_i & w_adr_ok;

  // Lock and address/cycle tags are accepted but have no effect.
  assign w_unused = ^{tgt_tga_i, tgt_tgc_i, tgt_lock_i, w_head.we};

  // Commit selected lanes at accept; a read in the same edge sees the old word.
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      for (int i = 0; i < SEL_WIDTH; i++) begin
        if (tgt_sel_i[i]) begin
          r_mem[w_idx][i*LANE_W +: LANE_W] <= tgt_dat_i[i*LANE_W +: LANE_W];
        end
      end
      if (|tgt_sel_i) begin
        r_tag[w_idx] <= tgt_tgd_i;
      end
    end
  end

  // Build the queue entry; errors and writes return zero data and tag.
  always_comb begin
    w_push_ent     = '0;
    w_push_ent.err = ~w_adr_ok;
    w_push_ent.we  = tgt_we_i;
    if (w_adr_ok && !tgt_we_i) begin
      w_push_ent.rdata = r_mem[w_idx];
      w_push_ent.rtag  = r_tag[w_idx];
    end
  end

  wb_tgt_queue #(
    .WIDTH (ENT_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .i_clk   (clk_i),
    .i_rst   (sync_rst_i),
    .i_push  (w_req),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (w_push_ent),
    .o_dout  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head  = w_head_bits;
  assign w_resp  = (r_state == ST_RESP) & tgt_cyc_i;
  assign w_pop   = w_resp;
  // Dropping the cycle abandons everything outstanding.
  assign w_flush = ~tgt_cyc_i;
  // Queue still holds something after this edge's pop.
  assign w_more  = (w_count > CNT_W'(1)) | w_req;

  // Sequencer state and delay counter.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: each head waits DLY cycles, then terminates for one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!tgt_cyc_i) begin
      w_state_nxt = ST_EMPTY;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_req) begin
            w_state_nxt = (DLY == '0) ? ST_RESP : ST_WAIT;
            w_cnt_nxt   = DLY;
          end
        end
        ST_WAIT: begin
          w_cnt_nxt = r_cnt - DLY_W'(1);
          if (r_cnt == DLY_W'(1)) begin
            w_state_nxt = ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_more) begin
            w_state_nxt = (DLY == '0) ? ST_RESP : ST_WAIT;
            w_cnt_nxt   = DLY;
          end else begin
            w_state_nxt = ST_EMPTY;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign tgt_ack_o    = w_resp & ~w_head.err;
  assign tgt_err_o    = w_resp & w_head.err;
  assign tgt_rty_o    = 1'b0;
  assign tgt_dat_o    = w_resp ? w_head.rdata : '0;
  assign tgt_tgd_o    = w_resp ? w_head.rtag : '0;
  assign tb_pending_o = w_count;

endmodule

// File: tb/tb_wb_tgt_mem.sv
// Scoreboard bench: two targets (zero and three-cycle delay) share one
// request stream; a reference model predicts each termination and its cycle.
module tb_wb_tgt_mem;

  localparam int QD = 4;

  logic        clk;
  logic        rst;
  logic        tb_stall;
  logic        cyc, stb, we, lock;
  logic [1:0]  sel;
  logic [15:0] adr;
  logic [15:0] dat;
  logic        tga, tgc, tgdi;

  logic        ack   [2];
  logic        err   [2];
  logic        rty   [2];
  logic        stall [2];
  logic [15:0] dato  [2];
  logic        tgdo  [2];
  logic [2:0]  pend  [2];

  wb_tgt_mem #(.QUEUE_DEPTH(QD), .RSP_DELAY(0)) u_dut0 (
    .clk_i(clk), .sync_rst_i(rst), .tb_stall_i(tb_stall),
    .tgt_cyc_i(cyc), .tgt_stb_i(stb), .tgt_we_i(we), .tgt_lock_i(lock),
    .tgt_sel_i(sel), .tgt_adr_i(adr), .tgt_dat_i(dat),
    .tgt_tga_i(tga), .tgt_tgc_i(tgc), .tgt_tgd_i(tgdi),
    .tgt_ack_o(ack[0]), .tgt_err_o(err[0]), .tgt_rty_o(rty[0]),
    .tgt_stall_o(stall[0]), .tgt_dat_o(dato[0]), .tgt_tgd_o(tgdo[0]),
    .tb_pending_o(pend[0]));

  wb_tgt_mem #(.QUEUE_DEPTH(QD), .RSP_DELAY(3)) u_dut1 (
    .clk_i(clk), .sync_rst_i(rst), .tb_stall_i(tb_stall),
    .tgt_cyc_i(cyc), .tgt_stb_i(stb), .tgt_we_i(we), .tgt_lock_i(lock),
    .tgt_sel_i(sel), .tgt_adr_i(adr), .tgt_dat_i(dat),
    .tgt_tga_i(tga), .tgt_tgc_i(tgc), .tgt_tgd_i(tgdi),
    .tgt_ack_o(ack[1]), .tgt_err_o(err[1]), .tgt_rty_o(rty[1]),
    .tgt_stall_o(stall[1]), .tgt_dat_o(dato[1]), .tgt_tgd_o(tgdo[1]),
    .tb_pending_o(pend[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        we;
    logic [15:0] dat;
    logic        tag;
    int          due;
  } exp_t;

  exp_t        sq0[$];
  exp_t        sq1[$];
  logic [15:0] mm [2][256];
  logic        mt [2][256];
  int          last_due [2];
  bit          acc [2];
  bit          got [2];
  logic [15:0] last_rd [2];
  int          nerr [2];
  int          t1[$];
  int          cycn;
  bit          mon_en;
  int          checks;
  int          failures;

  function automatic int qsz(input int k);
    return (k == 0) ? sq0.size() : sq1.size();
  endfunction

  function automatic exp_t qhead(input int k);
    return (k == 0) ? sq0[0] : sq1[0];
  endfunction

  task automatic qpop(input int k);
    if (k == 0) void'(sq0.pop_front());
    else        void'(sq1.pop_front());
  endtask

  task automatic qpush(input int k, input exp_t e);
    if (k == 0) sq0.push_back(e);
    else        sq1.push_back(e);
  endtask

  task automatic qclr(input int k);
    if (k == 0) sq0.delete();
    else        sq1.delete();
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h want=%0h cycle=%0d", nm, k, act, exp, cycn);
    end
  endtask

  // Reference model: applies accepted requests, predicts response cycle.
  always @(posedge clk) begin
    exp_t        e;
    int          d;
    logic [15:0] mask;
    for (int k = 0; k < 2; k++) begin
      if (rst || !cyc) begin
        qclr(k);
        last_due[k] = -1000;
      end else if (acc[k]) begin
        d     = (k == 0) ? 0 : 3;
        e.err = (adr >= 16'd256);
        e.we  = we;
        e.dat = '0;
        e.tag = 1'b0;
        if (!e.err) begin
          if (we) begin
            mask = {{8{sel[1]}}, {8{sel[0]}}};
            mm[k][adr[7:0]] = (mm[k][adr[7:0]] & ~mask) | (dat & mask);
            if (sel != 2'b00) mt[k][adr[7:0]] = tgdi;
          end else begin
            e.dat = mm[k][adr[7:0]];
            e.tag = mt[k][adr[7:0]];
          end
        end
        e.due = cycn + 1 + d;
        if (last_due[k] + 1 + d > e.due) e.due = last_due[k] + 1 + d;
        last_due[k] = e.due;
        qpush(k, e);
        got[k] = 1'b1;
      end
    end
    cycn++;
  end

  // Monitor: compares whatever each target presents with the scoreboard head.
  always @(negedge clk) begin
    int   occ;
    bit   es;
    exp_t e;
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        occ = qsz(k);
        es  = (occ == QD) || tb_stall;
        chk("pending", k, 32'(pend[k]), 32'(occ));
        chk("stall", k, 32'(stall[k]), 32'(es));
        chk("rty", k, 32'(rty[k]), 32'd0);
        acc[k] = cyc && stb && !es && !rst;
        if (cyc && occ > 0 && qhead(k).due == cycn) begin
          e = qhead(k);
          qpop(k);
          chk("ack", k, 32'(ack[k]), 32'(!e.err));
          chk("err", k, 32'(err[k]), 32'(e.err));
          chk("dat", k, 32'(dato[k]), 32'(e.dat));
          chk("tgd", k, 32'(tgdo[k]), 32'(e.tag));
          if (ack[k] || err[k]) begin
            if (k == 1) t1.push_back(cycn);
            if (err[k]) nerr[k]++;
            if (!e.err && !e.we) last_rd[k] = dato[k];
          end
        end else begin
          chk("idle_out", k, {13'd0, ack[k], err[k], dato[k], tgdo[k]}, 32'd0);
        end
      end
    end
  end

  // Hold a request until both targets have taken it at least once.
  task automatic req(input bit w, input logic [15:0] a, input logic [1:0] s,
                     input logic [15:0] d, input logic t);
    int n;
    we = w; adr = a; sel = s; dat = d; tgdi = t; cyc = 1'b1; stb = 1'b1;
    got[0] = 1'b0; got[1] = 1'b0;
    n = 0;
    while (!(got[0] && got[1]) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(got[0] && got[1])) begin
      failures++;
      $display("FAIL accept_timeout adr=%0h got=%0b%0b want=11", a, got[1], got[0]);
    end
    checks++;
    stb = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qsz(0) != 0 || qsz(1) != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (qsz(0) != 0 || qsz(1) != 0) begin
      failures++;
      $display("FAIL drain left=%0d/%0d want=0", qsz(0), qsz(1));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int e0;
    int e1;
    checks = 0; failures = 0; cycn = 0; mon_en = 1'b0;
    last_due[0] = -1000; last_due[1] = -1000;
    nerr[0] = 0; nerr[1] = 0;
    rst = 1'b1; tb_stall = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; lock = 1'b0;
    sel = '0; adr = '0; dat = '0; tga = 1'b0; tgc = 1'b0; tgdi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    tb_stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tb_stall = 1'b0;
    @(negedge clk);
    chk("rst_pending", 1, 32'(pend[1]), 32'd0);
    @(posedge clk); #1;

    // Fill memory so every later read has a defined expectation.
    for (int a = 0; a < 256; a++) req(1'b1, 16'(a), 2'b11, 16'($urandom), 1'($urandom));
    drain();

    // Full write then read back.
    req(1'b1, 16'd3, 2'b11, 16'hA5A5, 1'b1);
    req(1'b0, 16'd3, 2'b00, 16'h0000, 1'b0);
    drain();
    chk("rd_a5a5", 0, 32'(last_rd[0]), 32'h0000A5A5);
    chk("rd_a5a5", 1, 32'(last_rd[1]), 32'h0000A5A5);

    // Low-lane write only.
    req(1'b1, 16'd3, 2'b01, 16'h1234, 1'b0);
    req(1'b0, 16'd3, 2'b00, 16'h0000, 1'b0);
    drain();
    chk("rd_lane", 0, 32'(last_rd[0]), 32'h0000A534);
    chk("rd_lane", 1, 32'(last_rd[1]), 32'h0000A534);

    // Out-of-range write must error and leave address 0 alone.
    e0 = nerr[0]; e1 = nerr[1];
    req(1'b1, 16'd256, 2'b11, 16'hFFFF, 1'b1);
    req(1'b0, 16'd0, 2'b00, 16'h0000, 1'b0);
    drain();
    chk("err_count", 0, 32'(nerr[0] - e0), 32'd1);
    chk("err_count", 1, 32'(nerr[1] - e1), 32'd1);

    // Six back-to-back reads through the delayed target.
    t1.delete();
    for (int i = 0; i < 6; i++) req(1'b0, 16'(10 + i), 2'b00, 16'h0, 1'b0);
    drain();
    chk("ack_total", 1, 32'(t1.size()), 32'd6);
    if (t1.size() == 6) begin
      for (int i = 1; i < 6; i++) chk("ack_gap", 1, 32'(t1[i] - t1[i-1]), 32'd4);
    end

    // Abort with three outstanding.
    for (int i = 0; i < 3; i++) req(1'b0, 16'(20 + i), 2'b00, 16'h0, 1'b0);
    cyc = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_pend", 1, 32'(pend[1]), 32'd0);
    @(posedge clk); #1;

    // Reset with two outstanding; memory must survive.
    req(1'b1, 16'd30, 2'b11, 16'h5A5A, 1'b1);
    drain();
    req(1'b0, 16'd30, 2'b00, 16'h0, 1'b0);
    req(1'b0, 16'd31, 2'b00, 16'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", 1, 32'(stall[1]), 32'd0);
    chk("rst_pend", 1, 32'(pend[1]), 32'd0);
    @(posedge clk); #1;
    last_rd[0] = '0; last_rd[1] = '0;
    req(1'b0, 16'd30, 2'b00, 16'h0, 1'b0);
    drain();
    chk("rd_after_rst", 0, 32'(last_rd[0]), 32'h00005A5A);
    chk("rd_after_rst", 1, 32'(last_rd[1]), 32'h00005A5A);

    // Random traffic including aborts, forced stalls and bad addresses.
    for (int i = 0; i < 2000; i++) begin
      cyc      = ($urandom_range(0, 19) != 0);
      stb      = ($urandom_range(0, 3) != 0);
      we       = 1'($urandom_range(0, 1));
      adr      = ($urandom_range(0, 9) == 0) ? 16'(256 + $urandom_range(0, 3))
                                             : 16'($urandom_range(0, 31));
      sel      = 2'($urandom_range(0, 3));
      dat      = 16'($urandom);
      tgdi     = 1'($urandom);
      tb_stall = ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
    end
    cyc = 1'b1; stb = 1'b0; tb_stall = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
